spart: RTL and testbench
========================

Name: spart

Overview:
Bus-side serial port (SPART) that sits directly downstream of the board-level SPART driver FSM. It decodes that driver's iocs/iorw/ioaddr transactions on a shared bidirectional 8-bit databus and holds a programmable 16-bit baud divisor. It serialises bytes onto txd and deserialises rxd into a receive buffer. The rda and tbr status lines flow back upstream.

Parameters:
DB_RESET, 16'd651, divisor loaded at reset (50 MHz clk, 4800 baud, 16x oversample)
OVERSAMPLE, 16, baud enables per serial bit; fixed at 16, start-bit mid-sample at OVERSAMPLE/2

Ports:
clk  in  1  system clock
rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
iocs  in  1  chip select; a transaction occurs on every clk edge where iocs=1
iorw  in  1  1=read (spart drives databus), 0=write (driver drives databus)
ioaddr  in  2  00 tx/rx buffer, 01 status, 10 DB low, 11 DB high
databus  inout  8  shared data bus
rda  out  1  receive data available
tbr  out  1  transmit buffer ready
txd  out  1  serial out, idle high
rxd  in  1  serial in, asynchronous

Behaviour:
- Reset: txd=1, tbr=1, rda=0, DB=DB_RESET, rx buffer=0, error flags=0, both FSMs IDLE, databus Z.
- Bus drive: databus is driven combinationally only when iocs=1 and iorw=1; otherwise Z.
  - Read 00: rx buffer.
  - Read 01: {4'b0, overrun, frame_err, rda, tbr}.
  - Read 10: DB[7:0].
  - Read 11: DB[15:8].
- Writes (iocs=1, iorw=0), captured at the clk edge:
  - 00: loads tx buffer, only if tbr=1; ignored if tbr=0.
  - 01: ignored.
  - 10: writes DB[7:0].
  - 11: writes DB[15:8] and reloads the baud counter from the new DB.
- Read side effects:
  - Read of 00 clears rda at the next edge.
  - Read of 01 clears frame_err and overrun at the next edge; tbr/rda are unaffected.
- Baud generator:
  - 16-bit down counter loaded with DB.
  - When the count is 0: emits a one-cycle en pulse and reloads DB. Period = DB+1 clocks; DB=0 gives en every cycle.
  - Runs continuously and is shared by TX and RX.
- TX FSM: IDLE, START, DATA, STOP.
  - A write to 00 with tbr=1 loads the shift register, drops tbr on the next cycle, and enters START with txd=0 from the next cycle.
  - Each bit lasts 16 en pulses, counted by a 4-bit tick counter.
  - Data goes out LSB first, 8 bits, counted by a 3-bit bit counter; then txd=1 for the 16-en STOP bit.
  - tbr=1 on the cycle after the 16th STOP en, returning to IDLE.
  - Frame length = 160 en, ±1 partial en period at START.
- RX path: rxd passes through a 2-flop synchroniser; rxs is the synchronised value.
- RX FSM: IDLE, START, DATA, STOP.
  - IDLE: rxs=0 enters START and clears the tick counter.
  - START: after 8 en, if rxs=1 it is a false start and returns to IDLE with no flags; else enters DATA.
  - DATA: samples rxs every 16 en into the MSB of the shift register with right shift, 8 samples.
  - STOP: samples after 16 en.
    - If rxs=1: rx buffer is written, rda=1, and overrun=1 if rda was already 1 (new byte overwrites).
    - If rxs=0: frame_err=1, byte discarded, rda unchanged.
  - Returns to IDLE in all cases.
- Simultaneous events:
  - An RX completion and a read of 00 in the same cycle: new byte stored, rda stays 1, no overrun.
  - A status read and a new error in the same cycle: the new error wins, flag is set.
  - A DB write mid-frame: takes effect at the next counter reload; the frame is not aborted.
- Reset mid-frame: both FSMs go to IDLE immediately, txd=1; a partial RX byte is discarded.

Test Plan:
- Reset then read 10, 11, 01 -> databus = 8'h8B, 8'h02, 8'h01 (tbr=1, rda=0); txd=1, databus Z when iocs=0.
- Write DB=16'h0000, then write 8'hA5 to 00 -> tbr=0 next cycle; txd = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 16 clocks; tbr=1 after 160 clocks.
- Write to 00 while tbr=0 -> ignored; the transmitted frame still carries the first byte.
- DB=3 (bit = 64 clocks), drive rxd with frame for 8'h3C -> rda=1 after stop sample; read 00 returns 8'h3C, rda=0 next cycle.
- Two frames 8'h11, 8'h22 without reading -> read 01 shows overrun=1 (8'h0B); read 00 = 8'h22; second status read = 8'h01.
- rxd stop bit 0 -> frame_err=1 (status 8'h05), rda=0. Then a 4-clock rxd glitch low (DB=3) -> false start, no flags, next valid frame received correctly.
- Assert rst_n low mid-TX frame -> txd=1, tbr=1 immediately; DB back to 651.

Source files
------------

// File: rtl/spart.sv
// Bus-side serial port: register decode, baud generator,
// UART transmitter and receiver.
module spart #(
  parameter logic [15:0] DB_RESET   = 16'd651,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  logic wr, rd;
  logic wr_tx, wr_dbl, wr_dbh;
  logic rd_rx, rd_st;

  assign wr     = iocs & ~iorw;
  assign rd     = iocs & iorw;
  assign wr_tx  = wr & (ioaddr == 2'b00);
  assign wr_dbl = wr & (ioaddr == 2'b10);
  assign wr_dbh = wr & (ioaddr == 2'b11);
  assign rd_rx  = rd & (ioaddr == 2'b00);
  assign rd_st  = rd & (ioaddr == 2'b01);

  logic [15:0] db;
  logic [15:0] baud_cnt;
  logic        en;

  logic [7:0] rx_buf;
  logic       ovr, fe;
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      2'b00: rd_data = rx_buf;
      2'b01: rd_data = {4'b0, ovr, fe, rda, tbr};
      2'b10: rd_data = db[7:0];
      2'b11: rd_data = db[15:8];
    endcase
  end

  assign databus = rd ? rd_data : 8'bz;

  // Shared baud enable; a high-byte write restarts the count.
  assign en = (baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db       <= DB_RESET;
      baud_cnt <= DB_RESET;
    end else begin
      if (wr_dbl) db[7:0] <= databus;
      if (wr_dbh) begin
        db[15:8] <= databus;
        baud_cnt <= {databus, db[7:0]};
      end else if (en) begin
        baud_cnt <= db;
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  state_t     tx_st, tx_st_n;
  logic [3:0] tx_tick, tx_tick_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_sh, tx_sh_n;

  assign tbr = (tx_st == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st   <= IDLE;
      tx_tick <= 4'd0;
      tx_bit  <= 3'd0;
      tx_sh   <= 8'h00;
    end else begin
      tx_st   <= tx_st_n;
      tx_tick <= tx_tick_n;
      tx_bit  <= tx_bit_n;
      tx_sh   <= tx_sh_n;
    end
  end

  always_comb begin
    tx_st_n   = tx_st;
    tx_tick_n = tx_tick;
    tx_bit_n  = tx_bit;
    tx_sh_n   = tx_sh;
    txd       = 1'b1;
    unique case (tx_st)
      IDLE: begin
        if (wr_tx) begin
          tx_sh_n   = databus;
          tx_tick_n = 4'd0;
          tx_st_n   = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (en) begin
          tx_tick_n = tx_tick + 4'd1;
          if (tx_tick == TICK_LAST) begin
            tx_tick_n = 4'd0;
            tx_bit_n  = 3'd0;
            tx_st_n   = DATA;
          end
        end
      end
      DATA: begin
        txd = tx_sh[0];
        if (en) begin
          tx_tick_n = tx_tick + 4'd1;
          if (tx_tick == TICK_LAST) begin
            tx_tick_n = 4'd0;
            tx_sh_n   = {1'b0, tx_sh[7:1]};
            tx_bit_n  = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_st_n = STOP;
          end
        end
      end
      STOP: begin
        if (en) begin
          tx_tick_n = tx_tick + 4'd1;
          if (tx_tick == TICK_LAST) begin
            tx_tick_n = 4'd0;
            tx_st_n   = IDLE;
          end
        end
      end
    endcase
  end

  logic rx_meta, rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  state_t     rx_st, rx_st_n;
  logic [3:0] rx_tick, rx_tick_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic [7:0] rx_buf_n;
  logic       rda_n, ovr_n, fe_n;
  logic       done_ok, done_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= IDLE;
      rx_tick <= 4'd0;
      rx_bit  <= 3'd0;
      rx_sh   <= 8'h00;
      rx_buf  <= 8'h00;
      rda     <= 1'b0;
      ovr     <= 1'b0;
      fe      <= 1'b0;
    end else begin
      rx_st   <= rx_st_n;
      rx_tick <= rx_tick_n;
      rx_bit  <= rx_bit_n;
      rx_sh   <= rx_sh_n;
      rx_buf  <= rx_buf_n;
      rda     <= rda_n;
      ovr     <= ovr_n;
      fe      <= fe_n;
    end
  end

  always_comb begin
    rx_st_n   = rx_st;
    rx_tick_n = rx_tick;
    rx_bit_n  = rx_bit;
    rx_sh_n   = rx_sh;
    done_ok   = 1'b0;
    done_bad  = 1'b0;
    unique case (rx_st)
      IDLE: begin
        if (!rxs) begin
          rx_tick_n = 4'd0;
          rx_st_n   = START;
        end
      end
      START: begin
        if (en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == TICK_MID) begin
            rx_tick_n = 4'd0;
            rx_bit_n  = 3'd0;
            rx_st_n   = rxs ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == TICK_LAST) begin
            rx_tick_n = 4'd0;
            rx_sh_n   = {rxs, rx_sh[7:1]};
            rx_bit_n  = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st_n = STOP;
          end
        end
      end
      STOP: begin
        if (en) begin
          rx_tick_n = rx_tick + 4'd1;
          if (rx_tick == TICK_LAST) begin
            rx_tick_n = 4'd0;
            rx_st_n   = IDLE;
            done_ok   = rxs;
            done_bad  = ~rxs;
          end
        end
      end
    endcase
  end

  // A completion in the same cycle as a flag-clearing read wins.
  always_comb begin
    rx_buf_n = done_ok ? rx_sh : rx_buf;
    rda_n    = done_ok | (rda & ~rd_rx);
    ovr_n    = (done_ok & rda & ~rd_rx) | (ovr & ~rd_st);
    fe_n     = done_bad | (fe & ~rd_st);
  end

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: register table,
// TX bit scoreboard, RX byte scoreboard with flag model.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic       rxd = 1'b1;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] databus;
  wire        rda, tbr, txd;

  assign databus = drv_en ? drv : 8'bz;

  spart dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic       txq[$];
  logic [7:0] rxq[$];
  bit         m_ovr = 0;
  bit         m_fe = 0;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 0; ioaddr = a; drv = d; drv_en = 1;
    @(negedge clk);
    iocs = 0; drv_en = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 0; iorw = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [7:0] d;
    if (v.rw) begin
      bus_read(v.a, d);
      check($sformatf("vec%0d_rd%0d", idx, v.a), d, v.exp);
    end else begin
      bus_write(v.a, v.d);
    end
  endtask

  task automatic status_check(input string name);
    logic [7:0] d;
    logic [7:0] exp;
    exp = {4'b0, m_ovr, m_fe, rxq.size() > 0, 1'b1};
    bus_read(2'b01, d);
    check(name, d, exp);
    m_ovr = 0;
    m_fe = 0;
  endtask

  task automatic rx_read(input string name);
    logic [7:0] d;
    logic [7:0] exp;
    exp = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
    bus_read(2'b00, d);
    check(name, d, exp);
  endtask

  // 64-clock bits (DB=3); a bad stop bit is cut short so
  // the following idle line reads as a false start.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      if (rxq.size() > 0) begin
        rxq.delete();
        m_ovr = 1;
      end
      rxq.push_back(b);
    end else begin
      m_fe = 1;
    end
    @(negedge clk);
    rxd = 0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (64) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (stop_ok ? 64 : 48) @(negedge clk);
    rxd = 1;
    repeat (40) @(negedge clk);
  endtask

  vec_t t_reset[3];
  vec_t t_post[7];

  initial begin
    logic [7:0] tx_byte;

    t_reset[0] = '{1'b1, 2'b10, 8'h00, 8'h8B};
    t_reset[1] = '{1'b1, 2'b11, 8'h00, 8'h02};
    t_reset[2] = '{1'b1, 2'b01, 8'h00, 8'h01};
    t_post[0]  = '{1'b1, 2'b10, 8'h00, 8'h8B};
    t_post[1]  = '{1'b1, 2'b11, 8'h00, 8'h02};
    t_post[2]  = '{1'b1, 2'b01, 8'h00, 8'h01};
    t_post[3]  = '{1'b0, 2'b10, 8'h34, 8'h00};
    t_post[4]  = '{1'b1, 2'b10, 8'h00, 8'h34};
    t_post[5]  = '{1'b0, 2'b11, 8'h12, 8'h00};
    t_post[6]  = '{1'b1, 2'b11, 8'h00, 8'h12};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_txd", {7'b0, txd}, 8'h01);
    check("reset_tbr", {7'b0, tbr}, 8'h01);
    check("reset_rda", {7'b0, rda}, 8'h00);
    for (int i = 0; i < 3; i++) apply_vec(t_reset[i], i);

    // Transmit at one enable per clock.
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    tx_byte = 8'hA5;
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(tx_byte[i]);
    txq.push_back(1'b1);
    bus_write(2'b00, tx_byte);
    check("tx_tbr_drop", {7'b0, tbr}, 8'h00);
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      if (m == 30) begin
        iocs = 1; iorw = 0; ioaddr = 2'b00;
        drv = 8'h5A; drv_en = 1;
      end
      if (m == 31) begin
        iocs = 0; drv_en = 0;
      end
      if (m % 16 == 8 && m < 160) begin
        logic e;
        e = (txq.size() > 0) ? txq.pop_front() : 1'bx;
        check($sformatf("tx_bit%0d", m / 16), {7'b0, txd}, {7'b0, e});
      end
      if (m == 159) check("tx_tbr_busy", {7'b0, tbr}, 8'h00);
      if (m == 160) check("tx_tbr_back", {7'b0, tbr}, 8'h01);
      if (m == 200) check("tx_idle_after", {7'b0, txd}, 8'h01);
    end

    // Receive at DB=3.
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    send_frame(8'h3C, 1);
    check("rx_rda_set", {7'b0, rda}, 8'h01);
    rx_read("rx_3c");
    check("rx_rda_clr", {7'b0, rda}, 8'h00);

    send_frame(8'h11, 1);
    send_frame(8'h22, 1);
    status_check("rx_ovr_status");
    rx_read("rx_22");
    status_check("rx_status_clr");

    send_frame(8'h55, 0);
    check("fe_rda", {7'b0, rda}, 8'h00);
    status_check("fe_status");

    @(negedge clk);
    rxd = 0;
    repeat (4) @(negedge clk);
    rxd = 1;
    repeat (80) @(negedge clk);
    status_check("glitch_status");
    send_frame(8'hC3, 1);
    rx_read("rx_c3");

    // Reset in the middle of a transmit frame.
    bus_write(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    check("mid_tbr", {7'b0, tbr}, 8'h00);
    check("mid_txd", {7'b0, txd}, 8'h00);
    rst_n = 0;
    #1;
    check("rst_txd", {7'b0, txd}, 8'h01);
    check("rst_tbr", {7'b0, tbr}, 8'h01);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) apply_vec(t_post[i], 10 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
